mem_port_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the 16-word, 32-bit word-addressed program/data memory. Port 0 is instruction fetch, port 1 is load/store. Each access is accepted under a req/gnt handshake, presented to the memory for one cycle, and returned as a one-cycle response with data or error. Ties are resolved round-robin. Illegal addresses are rejected without touching memory.

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter and single-access sequencer for the word-addressed
// program/data memory: IDLE picks a winner, ACCESS drives memory, RESP returns data.
module mem_port_arbiter #(
    parameter int DEPTH_WORDS = 16,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              busy,
    output logic [31:0]       mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

    state_t            r_state, w_next;
    logic              r_last;
    logic              r_port;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_gnt;
    logic [1:0]        r_rvalid;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;
    logic              r_err0, r_err1;

    logic              w_any;
    logic              w_win;
    logic              w_illegal;
    logic              w_access;
    logic [DATA_W-1:0] w_rd;

    assign w_any     = req0 | req1;
    // On a tie the port that was not served last wins; r_last resets to 1 so port 0 wins first.
    assign w_win     = req1 & (~req0 | ~r_last);
    assign w_illegal = (r_addr[1:0] != 2'b00) || (r_addr >= LIMIT);
    assign w_access  = (r_state == ACCESS);
    assign w_rd      = (r_we || w_illegal) ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_port   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            if (r_state == IDLE && w_any) begin
                r_port        <= w_win;
                r_addr        <= w_win ? addr1  : addr0;
                r_we          <= w_win ? we1    : we0;
                r_wdata       <= w_win ? wdata1 : wdata0;
                r_gnt[w_win]  <= 1'b1;
                r_last        <= w_win;
            end
            if (w_access) begin
                r_rvalid[r_port] <= 1'b1;
                if (r_port) begin
                    r_rdata1 <= w_rd;
                    r_err1   <= w_illegal;
                end else begin
                    r_rdata0 <= w_rd;
                    r_err0   <= w_illegal;
                end
            end
        end
    end

    assign gnt0      = r_gnt[0];
    assign gnt1      = r_gnt[1];
    assign rvalid0   = r_rvalid[0];
    assign rvalid1   = r_rvalid[1];
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign err0      = r_err0;
    assign err1      = r_err1;
    assign busy      = (r_state != IDLE);
    assign mem_addr  = w_access ? r_addr  : '0;
    assign mem_wdata = w_access ? r_wdata : '0;
    // Reset in the access cycle must not let a write reach memory.
    assign mem_we    = w_access & r_we & ~w_illegal & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle-numbered transaction model plus directed
// scenarios with literal expectations, over a 16-word behavioural memory.
module tb_mem_port_arbiter;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem    [DEPTH];
    logic [31:0] shadow [DEPTH];

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.DEPTH_WORDS(DEPTH), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_we && mem_addr < 32'(DEPTH * 4)) mem[mem_addr[5:2]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    function automatic bit legal_f(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < DEPTH);
    endfunction

    // Model: one transaction at a time, granted in cycle g, response in g+1,
    // arbiter free again from cycle g+2 onward.
    int          n = 0;
    bit          model_ok = 0;
    int          busy_until = 0;
    bit          last = 1;
    bit          txn_v = 0;
    bit          t_port, t_we, t_err;
    int          t_g;
    logic [31:0] t_addr, t_wd, t_rd;

    always @(posedge clk) begin
        n++;
        if (rst) begin
            txn_v      = 0;
            busy_until = n;
            last       = 1;
        end else begin
            if (txn_v && t_g == n - 1) begin
                t_err = !legal_f(t_addr);
                if (t_we && !t_err) shadow[t_addr[5:2]] = t_wd;
                t_rd = (!t_we && !t_err) ? shadow[t_addr[5:2]] : 32'h0;
            end
            if (n - 1 >= busy_until && (req0 || req1)) begin
                t_port     = (req0 && req1) ? !last : req1;
                t_addr     = t_port ? addr1  : addr0;
                t_we       = t_port ? we1    : we0;
                t_wd       = t_port ? wdata1 : wdata0;
                t_g        = n;
                busy_until = n + 2;
                last       = t_port;
                txn_v      = 1;
            end
        end
        model_ok = 1;
    end

    logic acc, rsp;
    always @(negedge clk) begin
        if (model_ok) begin
            acc = txn_v && n == t_g;
            rsp = txn_v && n == t_g + 1;
            chk("gnt0",      gnt0,      32'(acc && !t_port));
            chk("gnt1",      gnt1,      32'(acc &&  t_port));
            chk("rvalid0",   rvalid0,   32'(rsp && !t_port));
            chk("rvalid1",   rvalid1,   32'(rsp &&  t_port));
            chk("rdata0",    rdata0,    (rsp && !t_port) ? t_rd : 32'h0);
            chk("rdata1",    rdata1,    (rsp &&  t_port) ? t_rd : 32'h0);
            chk("err0",      err0,      32'(rsp && !t_port && t_err));
            chk("err1",      err1,      32'(rsp &&  t_port && t_err));
            chk("busy",      busy,      32'(acc || rsp));
            chk("mem_addr",  mem_addr,  acc ? t_addr : 32'h0);
            chk("mem_wdata", mem_wdata, acc ? t_wd   : 32'h0);
            chk("mem_we",    mem_we,    32'(acc && t_we && legal_f(t_addr) && !rst));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input bit p, input logic [31:0] a, input bit w, input logic [31:0] d,
                        output bit rv, output logic [31:0] rd, output bit er);
        bit got = 0;
        if (p) begin req1 = 1; addr1 = a; we1 = w; wdata1 = d; end
        else   begin req0 = 1; addr0 = a; we0 = w; wdata0 = d; end
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (p ? gnt1 : gnt0) got = 1;
        end
        req0 = 0; req1 = 0;
        chk("gnt_seen", 32'(got), 32'd1);
        tick();
        @(negedge clk);
        rv = p ? rvalid1 : rvalid0;
        rd = p ? rdata1  : rdata0;
        er = p ? err1    : err0;
        tick();
    endtask

    int          gport [8];
    int          gcyc  [8];
    int          ng;
    bit          rv, er;
    logic [31:0] rd;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = 32'h1000 + 32'(i);
            shadow[i] = 32'h1000 + 32'(i);
        end
        mem[2] = 32'd99; shadow[2] = 32'd99;
        rst = 1; req0 = 1; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        // Reset held with req0 high, then release.
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        tick();
        rst = 0;
        tick();
        req0 = 0;
        @(negedge clk);
        chk("rel_gnt0", 32'(gnt0), 32'd1);
        tick();
        @(negedge clk);
        chk("rel_rvalid0", 32'(rvalid0), 32'd1);
        chk("rel_rdata0",  rdata0, 32'h1000);
        tick();

        // Single read of word 2.
        xact(0, 32'h8, 0, 0, rv, rd, er);
        chk("rd_rvalid", 32'(rv), 32'd1);
        chk("rd_rdata",  rd, 32'd99);
        chk("rd_err",    32'(er), 32'd0);

        // Write then read back.
        xact(1, 32'hC, 1, 32'hDEADBEEF, rv, rd, er);
        chk("wr_rdata",  rd, 32'h0);
        chk("wr_mem3",   mem[3], 32'hDEADBEEF);
        xact(0, 32'hC, 0, 0, rv, rd, er);
        chk("rb_rdata",  rd, 32'hDEADBEEF);

        // Illegal: misaligned read and out-of-range write.
        xact(0, 32'h6, 0, 0, rv, rd, er);
        chk("mis_err",   32'(er), 32'd1);
        chk("mis_rdata", rd, 32'h0);
        xact(1, 32'h40, 1, 32'h12345678, rv, rd, er);
        chk("oor_err",   32'(er), 32'd1);
        chk("oor_mem0",  mem[0], 32'h1000);

        // Round-robin with both ports held high right after reset.
        rst = 1;
        tick(); tick();
        req0 = 1; addr0 = 32'h10; we0 = 0;
        req1 = 1; addr1 = 32'h14; we1 = 0;
        rst = 0;
        ng = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            @(negedge clk);
            if ((gnt0 || gnt1) && ng < 8) begin
                gport[ng] = gnt1 ? 1 : 0;
                gcyc[ng]  = k;
                ng++;
            end
        end
        req0 = 0; req1 = 0;
        chk("rr_count", 32'(ng), 32'd4);
        for (int i = 0; i < ng && i < 4; i++) begin
            chk("rr_port", 32'(gport[i]), 32'(i % 2));
            if (i > 0) chk("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        tick(); tick(); tick();

        // Reset during the access cycle of a write to word 1.
        req1 = 1; addr1 = 32'h4; we1 = 1; wdata1 = 32'hBAD0BAD0;
        tick();
        chk("abort_gnt1", 32'(gnt1), 32'd1);
        rst = 1; req1 = 0;
        @(negedge clk);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        tick();
        rst = 0;
        @(negedge clk);
        chk("abort_rvalid1", 32'(rvalid1), 32'd0);
        chk("abort_busy",    32'(busy), 32'd0);
        chk("abort_mem1",    mem[1], 32'h1001);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
